// File: rtl/ahb_burst_write_master.sv
// AHB-Lite write master with an internal write-data FIFO.
// Issues SINGLE/INCR/WRAP bursts with pipelined address and data phases.
module ahb_burst_write_master #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk_master,
  input  logic                         rst_master,
  input  logic                         HREADY,
  input  logic                         HRESP,
  input  logic                         push_valid,
  input  logic [DATA_W-1:0]            push_data,
  output logic                         push_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            start_addr,
  input  logic [1:0]                   burst_len,
  input  logic                         wrap_en,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [ADDR_W-1:0]            HADDR,
  output logic                         HWRITE,
  output logic [2:0]                   HSIZE,
  output logic [2:0]                   HBURST,
  output logic [1:0]                   HTRANS,
  output logic [DATA_W-1:0]            HWDATA
);

  localparam int BYTES = DATA_W / 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BYTES);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_BURST, S_LAST} state_t;
  state_t state;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [3:0]        cnt, burst_last, req_last;
  logic [ADDR_W-1:0] wrap_mask, req_mask, start_aligned, next_addr;
  logic [7:0]        req_bytes;
  logic [10:0]       span_end;
  logic [LVL_W-1:0]  req_beats, remaining, discard;
  logic              push_en, pop, err_hit, crosses, req_wrap;

  assign HSIZE      = 3'($clog2(BYTES));
  assign push_ready = fifo_level < LVL_W'(FIFO_DEPTH);
  assign push_en    = push_valid && push_ready;
  assign pop        = HREADY && (HTRANS != 2'b00);
  assign err_hit    = HRESP && !HREADY && (state == S_BURST || state == S_LAST);

  always_comb begin
    req_last = 4'd15;
    case (burst_len)
      2'd0:    req_last = 4'd0;
      2'd1:    req_last = 4'd3;
      2'd2:    req_last = 4'd7;
      default: req_last = 4'd15;
    endcase
  end

  // INCR uses an all-ones mask so the wrap formula degenerates to HADDR+BYTES
  assign req_wrap      = wrap_en && (burst_len != 2'd0);
  assign req_beats     = LVL_W'(req_last) + LVL_W'(1);
  assign req_bytes     = (8'(req_last) + 8'd1) * 8'(BYTES);
  assign start_aligned = start_addr & ALIGN_MASK;
  assign span_end      = {1'b0, start_aligned[9:0]} + 11'(req_bytes);
  assign crosses       = !req_wrap && (span_end > 11'd1024);
  assign req_mask      = req_wrap ? ADDR_W'(req_bytes - 8'd1) : '1;
  assign next_addr     = (HADDR & ~wrap_mask) | ((HADDR + STEP) & wrap_mask);

  // In BURST with counter k, exactly k beats have been popped so far
  assign remaining = (state == S_BURST) ?
                     LVL_W'(burst_last) + LVL_W'(1) - LVL_W'(cnt) : '0;
  assign discard   = err_hit ? remaining : '0;

  always_ff @(posedge clk_master) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_master or posedge rst_master) begin
    if (rst_master) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr     <= rd_ptr + PTR_W'(pop) + discard[PTR_W-1:0];
      fifo_level <= fifo_level + LVL_W'(push_en) - LVL_W'(pop) - discard;
    end
  end

  always_ff @(posedge clk_master or posedge rst_master) begin
    if (rst_master) begin
      state      <= S_IDLE;
      HTRANS     <= 2'b00;
      HADDR      <= '0;
      HWRITE     <= 1'b0;
      HBURST     <= 3'b000;
      HWDATA     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cnt        <= '0;
      burst_last <= '0;
      wrap_mask  <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (pop) HWDATA <= mem[rd_ptr];
      case (state)
        S_IDLE: begin
          if (start && crosses) begin
            error <= 1'b1;
          end else if (start && fifo_level >= req_beats) begin
            state      <= S_ADDR;
            HTRANS     <= 2'b10;
            HADDR      <= start_aligned;
            HBURST     <= (burst_len == 2'd0) ? 3'b000 : {burst_len, ~wrap_en};
            HWRITE     <= 1'b1;
            busy       <= 1'b1;
            cnt        <= '0;
            burst_last <= req_last;
            wrap_mask  <= req_mask;
          end
        end
        S_ADDR: begin
          if (HREADY) begin
            if (burst_last == 4'd0) begin
              state  <= S_LAST;
              HTRANS <= 2'b00;
            end else begin
              state  <= S_BURST;
              HTRANS <= 2'b11;
              HADDR  <= next_addr;
              cnt    <= 4'd1;
            end
          end
        end
        S_BURST, S_LAST: begin
          if (err_hit) begin
            state  <= S_IDLE;
            HTRANS <= 2'b00;
            HWRITE <= 1'b0;
            busy   <= 1'b0;
            error  <= 1'b1;
          end else if (HREADY && state == S_LAST) begin
            state  <= S_IDLE;
            HWRITE <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else if (HREADY && cnt == burst_last) begin
            state  <= S_LAST;
            HTRANS <= 2'b00;
          end else if (HREADY) begin
            HADDR <= next_addr;
            cnt   <= cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_burst_write_master.sv
// Directed testbench for ahb_burst_write_master (DATA_W=32, FIFO_DEPTH=16).
module tb_ahb_burst_write_master;

  logic        clk_master = 1'b0;
  logic        rst_master = 1'b1;
  logic        HREADY = 1'b1, HRESP = 1'b0;
  logic        push_valid = 1'b0;
  logic [31:0] push_data = '0;
  logic        push_ready;
  logic [4:0]  fifo_level;
  logic        start = 1'b0;
  logic [31:0] start_addr = '0;
  logic [1:0]  burst_len = '0;
  logic        wrap_en = 1'b0;
  logic        busy, done, error, HWRITE;
  logic [31:0] HADDR, HWDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [1:0]  HTRANS;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_addr [16];
  logic [31:0] wrap_tab [8] = '{32'h38, 32'h3C, 32'h20, 32'h24,
                                32'h28, 32'h2C, 32'h30, 32'h34};

  ahb_burst_write_master #(.DATA_W(32), .ADDR_W(32), .FIFO_DEPTH(16)) dut (
    .clk_master(clk_master), .rst_master(rst_master),
    .HREADY(HREADY), .HRESP(HRESP),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .fifo_level(fifo_level),
    .start(start), .start_addr(start_addr), .burst_len(burst_len), .wrap_en(wrap_en),
    .busy(busy), .done(done), .error(error),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HTRANS(HTRANS), .HWDATA(HWDATA)
  );

  always #5 clk_master = ~clk_master;

  task automatic tick();
    @(posedge clk_master);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pushWords(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      push_valid = 1'b1;
      push_data  = base + 32'(i);
      tick();
    end
    push_valid = 1'b0;
  endtask

  // Pulses start for one edge; returns in the first address-phase cycle
  task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] len, input logic wrap);
    start = 1'b1; start_addr = addr; burst_len = len; wrap_en = wrap;
    tick();
    start = 1'b0;
  endtask

  task automatic fillIncr(input logic [31:0] base);
    for (int i = 0; i < 16; i++) exp_addr[i] = base + 32'(4 * i);
  endtask

  task automatic watchBurst(input int n, input logic [2:0] hb, input logic [31:0] dbase,
                            input int wait_beat, input int wait_cycles);
    int reps;
    for (int k = 0; k < n; k++) begin
      reps = (k == wait_beat) ? wait_cycles + 1 : 1;
      for (int r = 0; r < reps; r++) begin
        HREADY = (r == reps - 1);
        checkOutput("haddr", 64'(HADDR), 64'(exp_addr[k]));
        checkOutput("htrans", 64'(HTRANS), (k == 0) ? 64'h2 : 64'h3);
        checkOutput("hburst", 64'(HBURST), 64'(hb));
        checkOutput("hwrite", 64'(HWRITE), 64'h1);
        if (k > 0) checkOutput("hwdata", 64'(HWDATA), 64'(dbase + 32'(k - 1)));
        tick();
      end
    end
    HREADY = 1'b1;
    checkOutput("htrans_last", 64'(HTRANS), 64'h0);
    checkOutput("hwdata_last", 64'(HWDATA), 64'(dbase + 32'(n - 1)));
    checkOutput("hwrite_last", 64'(HWRITE), 64'h1);
    checkOutput("done_early", 64'(done), 64'h0);
    tick();
    checkOutput("done", 64'(done), 64'h1);
    checkOutput("busy_after", 64'(busy), 64'h0);
    tick();
    checkOutput("done_pulse", 64'(done), 64'h0);
  endtask

  initial begin
    // Reset values while reset is held
    repeat (2) @(posedge clk_master);
    #1;
    checkOutput("rst_htrans", 64'(HTRANS), 64'h0);
    checkOutput("rst_haddr", 64'(HADDR), 64'h0);
    checkOutput("rst_hwrite", 64'(HWRITE), 64'h0);
    checkOutput("rst_hburst", 64'(HBURST), 64'h0);
    checkOutput("rst_hwdata", 64'(HWDATA), 64'h0);
    checkOutput("rst_hsize", 64'(HSIZE), 64'h2);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_done", 64'(done), 64'h0);
    checkOutput("rst_error", 64'(error), 64'h0);
    checkOutput("rst_level", 64'(fifo_level), 64'h0);
    checkOutput("rst_ready", 64'(push_ready), 64'h1);
    rst_master = 1'b0;
    tick();

    // Zero-wait INCR4 at 0x100
    pushWords(32'hA0, 4);
    checkOutput("incr4_level", 64'(fifo_level), 64'h4);
    applyStimulus(32'h100, 2'd1, 1'b0);
    checkOutput("incr4_busy", 64'(busy), 64'h1);
    fillIncr(32'h100);
    watchBurst(4, 3'b011, 32'hA0, -1, 0);
    checkOutput("incr4_drained", 64'(fifo_level), 64'h0);

    // WRAP8 from 0x38
    pushWords(32'hB0, 8);
    applyStimulus(32'h38, 2'd2, 1'b1);
    for (int i = 0; i < 8; i++) exp_addr[i] = wrap_tab[i];
    watchBurst(8, 3'b100, 32'hB0, -1, 0);

    // INCR4 with two wait states on beat 2
    pushWords(32'hC0, 4);
    applyStimulus(32'h200, 2'd1, 1'b0);
    fillIncr(32'h200);
    watchBurst(4, 3'b011, 32'hC0, 2, 2);

    // ERROR on beat 1 of INCR8
    pushWords(32'hD0, 8);
    applyStimulus(32'h300, 2'd2, 1'b0);
    tick();
    tick();
    checkOutput("err_level_before", 64'(fifo_level), 64'h6);
    checkOutput("err_htrans_before", 64'(HTRANS), 64'h3);
    HRESP = 1'b1; HREADY = 1'b0;
    tick();
    HREADY = 1'b1;
    checkOutput("err_htrans", 64'(HTRANS), 64'h0);
    checkOutput("err_pulse", 64'(error), 64'h1);
    checkOutput("err_level", 64'(fifo_level), 64'h0);
    checkOutput("err_busy", 64'(busy), 64'h0);
    checkOutput("err_no_done", 64'(done), 64'h0);
    tick();
    HRESP = 1'b0;
    checkOutput("err_pulse_end", 64'(error), 64'h0);
    checkOutput("err_idle", 64'(HTRANS), 64'h0);
    tick();

    // Overflow: 17 pushes into 16 entries, then INCR16 drains in order
    pushWords(32'hE00, 17);
    checkOutput("ovf_level", 64'(fifo_level), 64'h10);
    checkOutput("ovf_ready", 64'(push_ready), 64'h0);
    applyStimulus(32'h400, 2'd3, 1'b0);
    fillIncr(32'h400);
    watchBurst(16, 3'b111, 32'hE00, -1, 0);
    checkOutput("ovf_drained", 64'(fifo_level), 64'h0);
    checkOutput("ovf_ready_again", 64'(push_ready), 64'h1);

    // INCR4 crossing 1KB is rejected with an error pulse
    pushWords(32'hF0, 4);
    applyStimulus(32'h3F8, 2'd1, 1'b0);
    checkOutput("kb_error", 64'(error), 64'h1);
    checkOutput("kb_htrans", 64'(HTRANS), 64'h0);
    checkOutput("kb_busy", 64'(busy), 64'h0);
    checkOutput("kb_level", 64'(fifo_level), 64'h4);
    tick();
    checkOutput("kb_error_end", 64'(error), 64'h0);
    checkOutput("kb_htrans2", 64'(HTRANS), 64'h0);

    // Reset asserted mid-burst
    applyStimulus(32'h0, 2'd1, 1'b0);
    tick();
    checkOutput("mid_htrans", 64'(HTRANS), 64'h3);
    rst_master = 1'b1;
    #1;
    checkOutput("mrst_htrans", 64'(HTRANS), 64'h0);
    checkOutput("mrst_haddr", 64'(HADDR), 64'h0);
    checkOutput("mrst_hwrite", 64'(HWRITE), 64'h0);
    checkOutput("mrst_hburst", 64'(HBURST), 64'h0);
    checkOutput("mrst_hwdata", 64'(HWDATA), 64'h0);
    checkOutput("mrst_busy", 64'(busy), 64'h0);
    checkOutput("mrst_level", 64'(fifo_level), 64'h0);
    checkOutput("mrst_ready", 64'(push_ready), 64'h1);
    tick();
    rst_master = 1'b0;
    tick();
    checkOutput("post_rst_htrans", 64'(HTRANS), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
